// File: rtl/uart_tx_8n1_fifo_if.sv
// User-side write port of the UART transmitter: byte, strobe, back-pressure and FIFO level.
interface uart_tx_8n1_fifo_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [7:0]                    tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (output tx_data, tx_valid, input tx_ready, fifo_count);
  modport slave  (input tx_data, tx_valid, output tx_ready, fifo_count);
endinterface

// File: rtl/uart_tx_8n1_fifo.sv
// FIFO-buffered UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// state  | meaning
// IDLE   | line high, waiting for a buffered byte
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even-parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit (high); next byte may start directly
module uart_tx_8n1_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_8n1_fifo_if.slave    bus,
  output logic                 tx,
  output logic                 tx_busy
);
  localparam int DIVISOR = CLK_FREQ / BAUD;
  localparam int CW      = $clog2(DIVISOR);
  localparam int PW      = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   count_q, count_d;

  state_t        state_q;
  logic [CW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  logic push, pop, have_data, baud_done;

  assign have_data = (count_q != '0);
  assign push      = bus.tx_valid && bus.tx_ready;
  assign baud_done = (baud_q == CW'(DIVISOR - 1));
  // The FIFO is popped either from idle or at the end of a stop bit, so frames chain without a gap.
  assign pop       = have_data && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_done));

  assign bus.tx_ready   = (count_q != (PW + 1)'(FIFO_DEPTH));
  assign bus.fifo_count = count_q;
  assign tx             = tx_q;
  assign tx_busy        = busy_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      if (state_q != S_IDLE) baud_q <= baud_done ? '0 : baud_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q  <= mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
            parity_q <= ^mem_q[rptr_q];
`endif
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            baud_q   <= '0;
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            tx_q    <= shift_q[0];
            bit_q   <= '0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx_q    <= parity_q;
              state_q <= S_PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (baud_done) begin
            if (pop) begin
              shift_q  <= mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
              parity_q <= ^mem_q[rptr_q];
`endif
              tx_q     <= 1'b0;
              state_q  <= S_START;
            end else begin
              busy_q   <= 1'b0;
              state_q  <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_8n1_fifo.sv
// Bench for uart_tx_8n1_fifo: frame-timing reference model, line receiver, vector table and random traffic.
module tb_uart_tx_8n1_fifo;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB    = PAR ? 11 : 10;
  localparam int FRAME = NB * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, tx_busy;

  uart_tx_8n1_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_8n1_fifo #(.CLK_FREQ(1600), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx(tx), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus a countdown of the cycles left in the frame on the line.
  logic [7:0] q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] cur = 8'h00;
  int  rem = 0;
  bit  last_acc = 1'b0;
  bit  rx_abort = 1'b0;

  task automatic model_step(input bit r, input bit v, input logic [7:0] d);
    int sz0;
    if (r) begin
      q.delete();
      exp_rx.delete();
      rem = 0;
      last_acc = 1'b0;
      rx_abort = 1'b1;
    end else begin
      sz0 = q.size();
      last_acc = v && (sz0 < DEPTH);
      if (rem <= 1) begin
        if (sz0 > 0) begin
          cur = q.pop_front();
          exp_rx.push_back(cur);
          rem = FRAME;
        end else begin
          rem = 0;
        end
      end else begin
        rem--;
      end
      if (last_acc) q.push_back(d);
    end
  endtask

  function automatic logic m_tx();
    int idx;
    if (rem == 0) return 1'b1;
    idx = (FRAME - rem) / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return cur[idx-1];
    if (PAR && idx == 9) return ^cur;
    return 1'b1;
  endfunction

  task automatic cyc(input bit r, input bit v, input logic [7:0] d);
    rst = r;
    bus.tx_valid = v;
    bus.tx_data = d;
    @(posedge clk);
    model_step(r, v, d);
    @(negedge clk);
    chk("tx", tx, m_tx());
    chk("tx_busy", tx_busy, rem != 0);
    chk("fifo_count", bus.fifo_count, q.size());
    chk("tx_ready", bus.tx_ready, q.size() < DEPTH);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rem != 0 || q.size() != 0) && n < budget) begin
      cyc(0, 0, 8'h00);
      n++;
    end
    chk("drain_timeout", (rem != 0 || q.size() != 0), 0);
  endtask

  // Line receiver: samples the middle of each bit, independent of the transmitter model.
  bit rx_on = 1'b0;
  int rx_cnt = 0;
  int rx_n = 0;
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk) begin
    int idx;
    if (rx_abort) begin
      rx_on = 1'b0;
      rx_abort = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % DIV == DIV / 2) begin
        idx = rx_cnt / DIV;
        if (idx == 0) chk("rx_start", tx, 0);
        else if (idx <= 8) rx_sh[idx-1] = tx;
        else if (PAR && idx == 9) chk("rx_parity", tx, ^rx_sh);
        else begin
          chk("rx_stop", tx, 1);
          if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
          else chk("rx_byte", rx_sh, exp_rx.pop_front());
          rx_n++;
          rx_on = 1'b0;
        end
      end
    end
  end

  typedef struct {
    bit         r;
    bit         v;
    logic [7:0] d;
    int         idle;
    bit         e_tx;
    bit         e_busy;
    int         e_cnt;
    bit         e_rdy;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [7:0] nxt;
    int base, accepted, guard;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

`ifndef UART_TX_PARITY_EN
    // 0x55 single frame, then 0xA3/0x0F/0xFF back-to-back
    tbl.push_back('{1, 0, 8'h00,   0, 1, 0, 0, 1});
    tbl.push_back('{0, 1, 8'h55,   0, 1, 0, 1, 1});
    tbl.push_back('{0, 0, 8'h00,   0, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00,  14, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00,   0, 1, 1, 0, 1});
    for (int b = 1; b < 8; b++) tbl.push_back('{0, 0, 8'h00, 15, b[0] ? 1'b0 : 1'b1, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00,  15, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00,  14, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00,   0, 1, 0, 0, 1});
    tbl.push_back('{0, 1, 8'hA3,   0, 1, 0, 1, 1});
    tbl.push_back('{0, 1, 8'h0F,   0, 0, 1, 1, 1});
    tbl.push_back('{0, 1, 8'hFF,   0, 0, 1, 2, 1});
    tbl.push_back('{0, 0, 8'h00, 157, 1, 1, 2, 1});
    tbl.push_back('{0, 0, 8'h00,   0, 0, 1, 1, 1});
    tbl.push_back('{0, 0, 8'h00, 159, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00, 158, 1, 1, 0, 1});
    tbl.push_back('{0, 0, 8'h00,   0, 1, 0, 0, 1});
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].v, tbl[i].d);
      repeat (tbl[i].idle) cyc(0, 0, 8'h00);
      chk($sformatf("vec%0d_tx", i), tx, tbl[i].e_tx);
      chk($sformatf("vec%0d_busy", i), tx_busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_count", i), bus.fifo_count, tbl[i].e_cnt);
      chk($sformatf("vec%0d_ready", i), bus.tx_ready, tbl[i].e_rdy);
    end
    chk("rx_after_table", rx_n, 4);
`else
    cyc(1, 0, 8'h00);
    chk("reset_tx", tx, 1);
    chk("reset_count", bus.fifo_count, 0);
    // Parity bit sits in bit period 9; frame is 176 clocks.
    cyc(0, 1, 8'h01);
    cyc(0, 0, 8'h00);
    repeat (150) cyc(0, 0, 8'h00);
    chk("parity_01", tx, 1);
    repeat (25) cyc(0, 0, 8'h00);
    chk("busy_175", tx_busy, 1);
    cyc(0, 0, 8'h00);
    chk("busy_176", tx_busy, 0);
    cyc(0, 1, 8'h03);
    cyc(0, 0, 8'h00);
    repeat (150) cyc(0, 0, 8'h00);
    chk("parity_03", tx, 0);
    drain(400);
`endif

    // Hold tx_valid high: FIFO fills, rejected writes never reach the line.
    nxt = 8'h00;
    base = rx_n;
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, nxt);
      if (last_acc) begin nxt++; accepted++; end
    end
    chk("fill_count", bus.fifo_count, 4);
    chk("fill_ready", bus.tx_ready, 0);
    for (int i = 0; i < 1200; i++) begin
      cyc(0, 1, nxt);
      if (last_acc) begin nxt++; accepted++; end
    end
    drain(2000);
    chk("fill_rx_total", rx_n - base, accepted);

    // Reset at clock 70 of a 0xC3 frame with two more bytes queued.
    cyc(0, 1, 8'hC3);
    cyc(0, 1, 8'h11);
    cyc(0, 1, 8'h22);
    repeat (67) cyc(0, 0, 8'h00);
    cyc(1, 0, 8'h00);
    chk("abort_tx", tx, 1);
    chk("abort_busy", tx_busy, 0);
    chk("abort_count", bus.fifo_count, 0);
    chk("abort_ready", bus.tx_ready, 1);
    base = rx_n;
    cyc(0, 1, 8'h5A);
    cyc(0, 0, 8'h00);
    chk("post_reset_start", tx, 0);
    drain(400);
    repeat (20) cyc(0, 0, 8'h00);
    chk("post_reset_rx", rx_n - base, 1);

    // 256 random bytes with random strobes.
    base = rx_n;
    accepted = 0;
    guard = 0;
    while (accepted < 256 && guard < 60000) begin
      nxt = 8'($urandom_range(0, 255));
      cyc(0, ($urandom_range(0, 3) != 0), nxt);
      if (last_acc) accepted++;
      guard++;
    end
    chk("random_timeout", accepted, 256);
    drain(2000);
    repeat (20) cyc(0, 0, 8'h00);
    chk("random_rx_total", rx_n - base, accepted);
    chk("exp_rx_empty", exp_rx.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_8n1_fifo.md
Name: uart_tx_8n1_fifo

Overview:
UART transmitter, the transmit-side companion to the 8N1 receiver, for the iCE40 UART examples. Frame format: 1 start bit, 8 data bits LSB first, 1 stop bit.
Bytes from the user side are buffered in a small FIFO and serialized on tx. The bit rate is generated internally from the system clock.
Sits between user logic (echo/loopback, message senders) and the FTDI UART pin.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; DIVISOR = CLK_FREQ / BAUD (integer division, truncated), must be >= 2
FIFO_DEPTH, 4, transmit FIFO entries; power of 2, >= 2

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous reset, active-high
tx_data  input  8  byte to send
tx_valid  input  1  write strobe; byte accepted on a clk edge where tx_valid && tx_ready
tx_ready  output  1  FIFO not full
tx  output  1  serial line, idle high, registered
tx_busy  output  1  high while a frame is on the line (state != IDLE)
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered, excluding the byte being shifted

Behaviour:
- Reset (rst=1 at a clk edge):
  - tx=1, tx_busy=0, tx_ready=1, fifo_count=0.
  - FIFO pointers cleared; state=IDLE; baud counter=0; bit counter=0.
  - Reset mid-frame aborts the frame: tx is high from the edge after rst is sampled. The frame is not resumed and buffered bytes are discarded.
- FIFO:
  - Circular buffer with read/write pointers of width $clog2(FIFO_DEPTH); pointers wrap modulo FIFO_DEPTH.
  - Push occurs when tx_valid && tx_ready. When full, tx_ready=0 and tx_valid is ignored; data is not overwritten.
  - A push and a pop in the same cycle leave fifo_count unchanged.
  - When full, push and pop cannot coincide, because the push is already rejected (tx_ready=0).
  - Ordering is strict FIFO.
- Baud counter: counts 0..DIVISOR-1 while state != IDLE. Bit boundary occurs when the counter reaches DIVISOR-1; counter then returns to 0. Each bit is held on tx for exactly DIVISOR clk cycles.
- State machine:
  - IDLE: tx=1. If fifo_count != 0: pop the head byte into an 8-bit shift register, tx<=0, go to START, baud counter=0.
  - START: tx=0 for DIVISOR cycles. At the boundary: tx<=shift[0], bit counter=0, go to DATA.
  - DATA: at each boundary, shift right and increment the bit counter; tx<=next bit. After bit 7's period: tx<=1, go to STOP.
  - STOP: tx=1 for DIVISOR cycles. At the boundary:
    - If fifo_count != 0: pop, tx<=0, go to START. This gives back-to-back frames with no idle gap.
    - Otherwise go to IDLE.
- Latency:
  - Byte pushed at edge N into an empty FIFO while IDLE: popped at edge N+1; tx falls at edge N+1.
  - Frame length is exactly 10*DIVISOR cycles (11*DIVISOR with parity enabled).
- tx_busy is 1 from the edge that leaves IDLE until the edge that returns to IDLE.
- tx changes only on clk edges and is glitch-free.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It transmits the even-parity bit (XOR of the 8 data bits) for DIVISOR cycles; the frame becomes 8E1, 11 bits.
- Undefined: no PARITY state, frame is 8N1 exactly as above, and there is no parity logic.

Test Plan:
All scenarios use CLK_FREQ=1600, BAUD=100, so DIVISOR=16.
1. Reset, then push 0x55 in one cycle → tx falls 1 cycle later. tx reads 0,1,0,1,0,1,0,1,0,1 with each level held 16 clks. tx_busy high for 160 clks, then IDLE with tx=1.
2. Push 0xA3, 0x0F, 0xFF in consecutive cycles → three frames back-to-back, 480 clks total, no idle cycles between stop and next start. fifo_count sequence: 1,2 → 2 → 1 → 0.
3. Hold tx_valid high with incrementing data 0x00.. → tx_ready drops after the FIFO fills (fifo_count=4). Rejected writes are never transmitted. Output bytes are 0x00,0x01,... with no gaps or duplicates.
4. Assert rst for 1 cycle at clk 70 of a 0xC3 frame → tx=1 from the next edge, fifo_count=0, tx_ready=1. A byte pushed afterward is sent as a complete, correct frame.
5. Decode tx with the 8N1 receiver model driven at 1 baud tick per 16 clks, over 256 random bytes → every byte received equals the byte sent.
6. With UART_TX_PARITY_EN defined: 0x01 → parity bit 1; 0x03 → parity bit 0; frame length 176 clks.
